// File: rtl/uart_rx.sv
// UART receive stage: synchronizes the serial pin, votes 3 samples per bit,
// assembles a frame with optional parity and hands it out over valid/ready.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 baud_tick_6th,
    input  logic                 baud_tick_8th,
    input  logic                 baud_tick_10th,
    input  logic                 baud_tick_16th,
    output logic                 baud_clear,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic [2:0]           dbg_state
);

    // Handshake: a frame moves on every cycle where rx_valid && rx_ready.
    // rx_valid never drops without that transfer; a new frame may replace
    // an unread one (rx_overrun pulse), keeping rx_valid high.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 s6_q, s8_q;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 vote;
    logic                 latch;

    // The 10th sample is taken live from the synchronizer at resolve time.
    assign vote = (s6_q & s8_q) | (s6_q & sync2_q) | (s8_q & sync2_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        latch      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                par_err_d = 1'b0;
                if (prev_q && !sync2_q) state_d = START;
            end
            START: begin
                if (baud_tick_10th && vote) state_d = IDLE;
                else if (baud_tick_16th)    state_d = DATA;
            end
            DATA: begin
                if (baud_tick_10th) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (baud_tick_16th) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = cfg_parity_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick_10th) par_err_d = vote ^ (^shift_q) ^ cfg_parity_odd;
                if (baud_tick_16th) state_d = STOP;
            end
            STOP: begin
                if (baud_tick_10th) begin
                    latch   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (latch) begin
            rx_data_d  = shift_q;
            rx_perr_d  = par_err_q & cfg_parity_en;
            rx_ferr_d  = ~vote;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            s6_q       <= 1'b1;
            s8_q       <= 1'b1;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            if (baud_tick_6th) s6_q <= sync2_q;
            if (baud_tick_8th) s8_q <= sync2_q;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign baud_clear    = (state_q == IDLE);
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural baud generator, directed frames, and a
// scoreboard of expected {data, parity_err, frame_err} words.
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       tick6, tick8, tick10, tick16;
    logic       baud_clear;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_overrun;
    logic [2:0] dbg_state;

    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ovr_cnt = 0;

    int         div_cnt = 0;
    logic [3:0] tick_cnt = 4'd0;

    uart_rx #(.DATA_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rxd       (uart_rxd),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .baud_tick_6th  (tick6),
        .baud_tick_8th  (tick8),
        .baud_tick_10th (tick10),
        .baud_tick_16th (tick16),
        .baud_clear     (baud_clear),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .rx_overrun     (rx_overrun),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // baud generator model: DIV clocks per tick, 16 ticks per bit
    always @(posedge clk) begin
        if (baud_clear) begin
            div_cnt  <= 0;
            tick_cnt <= 4'd0;
        end else if (div_cnt == DIV - 1) begin
            div_cnt  <= 0;
            tick_cnt <= tick_cnt + 4'd1;
        end else begin
            div_cnt  <= div_cnt + 1;
        end
    end
    assign tick6  = (div_cnt == DIV - 1) && (tick_cnt == 4'd5);
    assign tick8  = (div_cnt == DIV - 1) && (tick_cnt == 4'd7);
    assign tick10 = (div_cnt == DIV - 1) && (tick_cnt == 4'd9);
    assign tick16 = (div_cnt == DIV - 1) && (tick_cnt == 4'd15);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every transferred frame
    always @(negedge clk) begin
        if (!rst && rx_overrun) ovr_cnt++;
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {22'd0, rx_data, rx_parity_err, rx_frame_err}, 32'h3ff);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("frame", {22'd0, rx_data, rx_parity_err, rx_frame_err}, {22'd0, e});
            end
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
        uart_rxd = 1'b1;
    endtask

    task automatic idle(input int bits);
        uart_rxd = 1'b1;
        repeat (bits * BIT) @(negedge clk);
    endtask

    // one-cycle high pulse landing on the 8th-tick sample of data bit 3
    task automatic noise_bit3;
        int seen = 0;
        for (int c = 0; c < 20 * BIT; c++) begin
            @(negedge clk);
            if (div_cnt == DIV - 3 && tick_cnt == 4'd7) begin
                seen++;
                if (seen == 5) begin
                    uart_rxd = 1'b1;
                    @(negedge clk);
                    uart_rxd = 1'b0;
                    return;
                end
            end
        end
        chk("noise_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_perr", {31'd0, rx_parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("rst_baud_clear", {31'd0, baud_clear}, 32'd1);
        idle(1);

        // 8N1 0xA5
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 8E1 0x37 with wrong parity bit 0 (even parity bit should be 1)
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        exp_q.push_back({8'h37, 1'b1, 1'b0});
        send_frame(8'h37, 1'b1, 1'b0, 1'b1);
        idle(2);
        // 8O1 0x37 with correct parity bit 0
        cfg_parity_odd = 1'b1;
        exp_q.push_back({8'h37, 1'b0, 1'b0});
        send_frame(8'h37, 1'b1, 1'b0, 1'b1);
        idle(2);
        // 8E1 0x36 with correct parity bit 0
        cfg_parity_odd = 1'b0;
        exp_q.push_back({8'h36, 1'b0, 1'b0});
        send_frame(8'h36, 1'b1, 1'b0, 1'b1);
        idle(2);
        cfg_parity_en = 1'b0;

        // quarter-bit glitch: false start
        uart_rxd = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        idle(2);
        chk("glitch_baud_clear", {31'd0, baud_clear}, 32'd1);
        chk("glitch_state_idle", {29'd0, dbg_state}, 32'd0);

        // 0x00 with noise on data bit 3
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        fork
            send_frame(8'h00, 1'b0, 1'b0, 1'b1);
            noise_bit3();
        join
        idle(2);

        // back-to-back 0x11, 0x22 unread: overrun, 0x22 survives
        rx_ready = 1'b0;
        ovr_cnt = 0;
        exp_q.push_back({8'h22, 1'b0, 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("ovr_pulses", ovr_cnt, 32'd1);
        chk("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("ovr_data", {24'd0, rx_data}, 32'h22);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_clears_valid", {31'd0, rx_valid}, 32'd0);
        idle(1);

        // 0xFF with stop bit 0
        exp_q.push_back({8'hFF, 1'b0, 1'b1});
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        idle(2);

        // reset in the middle of a 0xFF frame
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * BIT) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
                chk("midrst_data", {24'd0, rx_data}, 32'd0);
                chk("midrst_ferr", {31'd0, rx_frame_err}, 32'd0);
                chk("midrst_baud_clear", {31'd0, baud_clear}, 32'd1);
            end
        join
        idle(2);

        // break: line held low for many bit times
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        uart_rxd = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        chk("break_state_idle", {29'd0, dbg_state}, 32'd0);
        idle(3);

        chk("total_overruns", ovr_cnt, 32'd1);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
